// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op and funct3 encodings, and MEM-stage FSM states.
// Also holds the misalignment predicate used by mem_stage.
package mem_stage_pkg;

   localparam int REG_ADDR_BUS = 5;
   localparam int REG_BUS      = 64;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;
   localparam logic [2:0] SD  = 3'b011;

   typedef enum logic [1:0] {
      MEMST_IDLE = 2'b00,
      MEMST_REQ  = 2'b01,
      MEMST_WAIT = 2'b10,
      MEMST_DONE = 2'b11
   } memst_e;

   // Store funct3 shares its low bits with the load size, so one predicate serves both.
   function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
      case (funct3)
         LH, LHU: return addr_lo[0];
         LW, LWU: return addr_lo[1:0] != 2'b00;
         LD:      return addr_lo != 3'b000;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data alignment: shifts the fetched doubleword down to the addressed lane
// and sign/zero-extends according to the load funct3.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [REG_BUS-1:0] ld_buf_i,
   input  logic [2:0]         addr_lo_i,
   input  logic [2:0]         funct3_i,
   output logic [REG_BUS-1:0] data_o
);

   logic [REG_BUS-1:0] lane;

   always_comb begin
      lane = ld_buf_i >> {addr_lo_i, 3'b000};
      case (funct3_i)
         LB:      data_o = {{56{lane[7]}}, lane[7:0]};
         LH:      data_o = {{48{lane[15]}}, lane[15:0]};
         LW:      data_o = {{32{lane[31]}}, lane[31:0]};
         LD:      data_o = lane;
         LBU:     data_o = {56'b0, lane[7:0]};
         LHU:     data_o = {48'b0, lane[15:0]};
         LWU:     data_o = {32'b0, lane[31:0]};
         default: data_o = {56'b0, lane[7:0]};
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: passes ALU results through and runs loads/stores over a
// req/gnt/rvalid handshake, stalling the pipeline. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REG_ADDR_BUS-1:0] rd_addr_i,
   input  logic                    wreg_i,
   input  logic [REG_BUS-1:0]      wdata_i,
   input  logic [1:0]              mem_op_i,
   input  logic [2:0]              mem_funct3_i,
   input  logic [REG_BUS-1:0]      mem_sdata_i,
   output logic                    dmem_req_o,
   output logic                    dmem_we_o,
   output logic [REG_BUS-1:0]      dmem_addr_o,
   output logic [REG_BUS-1:0]      dmem_wdata_o,
   output logic [7:0]              dmem_wmask_o,
   input  logic                    dmem_gnt_i,
   input  logic                    dmem_rvalid_i,
   input  logic [REG_BUS-1:0]      dmem_rdata_i,
   output logic                    stallreq_o,
   output logic                    misalign_o,
   output logic [REG_ADDR_BUS-1:0] rd_addr_o,
   output logic                    wreg_o,
   output logic [REG_BUS-1:0]      wdata_o
);

   memst_e             state_q, state_d;
   logic [REG_BUS-1:0] ld_buf_q, ld_buf_d;
   logic [REG_BUS-1:0] ld_ext;
   logic               is_load, is_store, is_mem, misalign;
   logic               req;
   logic [7:0]         mask_base;

   assign is_load  = (mem_op_i == MEM_OP_LOAD);
   assign is_store = (mem_op_i == MEM_OP_STORE);
   assign is_mem   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = is_mem & addr_misaligned(mem_funct3_i, wdata_i[2:0]);
`else
   assign misalign = 1'b0;
`endif

   mem_load_ext u_load_ext (
      .ld_buf_i  (ld_buf_q),
      .addr_lo_i (wdata_i[2:0]),
      .funct3_i  (mem_funct3_i),
      .data_o    (ld_ext)
   );

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      state_d    = state_q;
      ld_buf_d   = ld_buf_q;
      req        = 1'b0;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      case (state_q)
         MEMST_IDLE: begin
            if (is_mem) begin
               stallreq_o = 1'b1;
               if (misalign) begin
                  state_d = MEMST_DONE;
               end else begin
                  req     = 1'b1;
                  state_d = dmem_gnt_i ? MEMST_WAIT : MEMST_REQ;
               end
            end
         end
         MEMST_REQ: begin
            req        = 1'b1;
            stallreq_o = 1'b1;
            if (dmem_gnt_i) state_d = MEMST_WAIT;
         end
         MEMST_WAIT: begin
            stallreq_o = 1'b1;
            if (dmem_rvalid_i) begin
               if (is_load) ld_buf_d = dmem_rdata_i;
               state_d = MEMST_DONE;
            end
         end
         MEMST_DONE: begin
            state_d = MEMST_IDLE;
            if (misalign) begin
               misalign_o = 1'b1;
               wreg_o     = 1'b0;
            end else if (is_load) begin
               wdata_o = ld_ext;
            end
         end
         default: state_d = MEMST_IDLE;
      endcase
      // The held EX/MEM op would otherwise re-raise req from IDLE while reset is low.
      if (!rst) begin
         req        = 1'b0;
         stallreq_o = 1'b0;
      end
   end

   always_comb begin
      case (mem_funct3_i[1:0])
         2'b00:   mask_base = 8'h01;
         2'b01:   mask_base = 8'h03;
         2'b10:   mask_base = 8'h0F;
         default: mask_base = 8'hFF;
      endcase
   end

   assign rd_addr_o    = rd_addr_i;
   assign dmem_req_o   = req;
   assign dmem_we_o    = req & is_store;
   assign dmem_addr_o  = req ? {wdata_i[63:3], 3'b000} : '0;
   assign dmem_wdata_o = (req && is_store) ? (mem_sdata_i << {wdata_i[2:0], 3'b000}) : '0;
   assign dmem_wmask_o = (req && is_store) ? (mask_base << wdata_i[2:0]) : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= MEMST_IDLE;
         ld_buf_q <= '0;
      end else begin
         state_q  <= state_d;
         ld_buf_q <= ld_buf_d;
      end
   end

endmodule
